// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control FSM driving datapath strobes and mux selects.
// Latency: outputs are registered Moore decodes of state; FETCH ir_write/pc_write gated by ready same cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold until ready (mem_ready when WAIT_MEM=1, else always ready).
module mc_ctrl #(
    parameter bit WAIT_MEM  = 1'b1,
    parameter int ALUCTRL_W = 3,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic [3:0]           state,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instr_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_ORIEX  = 4'd8,
        S_ORIWB  = 4'd9,
        S_BEQ    = 4'd10,
        S_JAL    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // fetch marks FETCH; its ir_write/pc_write strobes are qualified by ready downstream.
    typedef struct packed {
        logic       fetch;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
    } ctl_t;

    function automatic ctl_t decode(input state_t s, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b11;
                c.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 2'b01;
                c.reg_dst    = 2'b00;
            end
            S_MEMWR: begin
                c.i_or_d    = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
            end
            S_RTWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b01;
            end
            S_ORIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = ALU_OR;
            end
            S_ORIWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 2'b00;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JAL: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.reg_write  = 1'b1;
                c.reg_dst    = 2'b10;
                c.mem_to_reg = 2'b10;
            end
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_q;
    state_t           state_nxt;
    ctl_t             ctl_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready;
    logic             retire;
    logic             fetch_go;

    assign ready = WAIT_MEM ? mem_ready : 1'b1;

    always_comb begin
        state_nxt = state_q;
        retire    = 1'b0;
        case (state_q)
            S_FETCH:  if (ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = (funct == FN_ADDU || funct == FN_SUBU) ? S_RTEX : S_TRAP;
                    OP_ORI:       state_nxt = S_ORIEX;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_TRAP;
                endcase
            end
            // IR is stable across the instruction, so op is simply re-examined here.
            S_MEMADR: begin
                if (op == OP_LW)      state_nxt = S_MEMRD;
                else if (op == OP_SW) state_nxt = S_MEMWR;
                else                  state_nxt = S_TRAP;
            end
            S_MEMRD:  if (ready) state_nxt = S_MEMWB;
            S_MEMWB: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_MEMWR: begin
                if (ready) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_RTEX:   state_nxt = S_RTWB;
            S_ORIEX:  state_nxt = S_ORIWB;
            S_RTWB, S_ORIWB, S_BEQ, S_JAL: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            S_TRAP:   state_nxt = S_TRAP;
            default:  state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctl_q     <= decode(S_FETCH, 6'h00);
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_nxt;
            ctl_q   <= decode(state_nxt, funct);
            if (state_nxt == S_TRAP) illegal_q <= 1'b1;
            if (retire) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // rst_n qualifies the fetch strobes so nothing is written while reset is held.
    assign fetch_go      = ctl_q.fetch & ready & rst_n;
    assign ir_write      = fetch_go;
    assign pc_write      = ctl_q.pc_write | fetch_go;
    assign pc_write_cond = ctl_q.pc_write_cond;
    assign i_or_d        = ctl_q.i_or_d;
    assign mem_read      = ctl_q.mem_read;
    assign mem_write     = ctl_q.mem_write;
    assign reg_write     = ctl_q.reg_write;
    assign alu_src_a     = ctl_q.alu_src_a;
    assign reg_dst       = ctl_q.reg_dst;
    assign mem_to_reg    = ctl_q.mem_to_reg;
    assign alu_src_b     = ctl_q.alu_src_b;
    assign pc_source     = ctl_q.pc_source;
    assign alu_ctrl      = ALUCTRL_W'(ctl_q.alu_op);
    assign state         = state_q;
    assign illegal       = illegal_q;
    assign instr_cnt     = cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: a WAIT_MEM=1/CNT_W=2 instance and a WAIT_MEM=0/CNT_W=16 instance
// checked every cycle against per-instruction state paths and a per-state output table.
module tb_mc_ctrl;

    logic       clk;
    logic       rst_w_n, rst_n_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;

    logic       w_pc_write, w_pc_write_cond, w_ir_write, w_i_or_d, w_mem_read, w_mem_write, w_reg_write, w_alu_src_a;
    logic [1:0] w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source;
    logic [2:0] w_alu_ctrl;
    logic [3:0] w_state;
    logic       w_illegal;
    logic [1:0] w_cnt;

    logic       n_pc_write, n_pc_write_cond, n_ir_write, n_i_or_d, n_mem_read, n_mem_write, n_reg_write, n_alu_src_a;
    logic [1:0] n_reg_dst, n_mem_to_reg, n_alu_src_b, n_pc_source;
    logic [2:0] n_alu_ctrl;
    logic [3:0] n_state;
    logic       n_illegal;
    logic [15:0] n_cnt;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_ctrl;
        logic [3:0] state;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         lat;
    } vec_t;

    typedef int path_t[$];

    obs_t ow, onn;
    int   n_vec, n_bad;
    int   m_cnt_w, m_cnt_n;
    int   cyc_acc, irp_acc;

    assign ow  = {w_pc_write, w_pc_write_cond, w_ir_write, w_i_or_d, w_mem_read, w_mem_write, w_reg_write,
                  w_alu_src_a, w_reg_dst, w_mem_to_reg, w_alu_src_b, w_pc_source, w_alu_ctrl, w_state, w_illegal};
    assign onn = {n_pc_write, n_pc_write_cond, n_ir_write, n_i_or_d, n_mem_read, n_mem_write, n_reg_write,
                  n_alu_src_a, n_reg_dst, n_mem_to_reg, n_alu_src_b, n_pc_source, n_alu_ctrl, n_state, n_illegal};

    mc_ctrl #(.WAIT_MEM(1'b1), .ALUCTRL_W(3), .CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_w_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .ir_write(w_ir_write), .i_or_d(w_i_or_d),
        .mem_read(w_mem_read), .mem_write(w_mem_write), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .alu_src_b(w_alu_src_b), .pc_source(w_pc_source),
        .alu_ctrl(w_alu_ctrl), .state(w_state), .illegal(w_illegal), .instr_cnt(w_cnt)
    );

    mc_ctrl #(.WAIT_MEM(1'b0), .ALUCTRL_W(3), .CNT_W(16)) dut_n (
        .clk(clk), .rst_n(rst_n_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .ir_write(n_ir_write), .i_or_d(n_i_or_d),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .alu_src_b(n_alu_src_b), .pc_source(n_pc_source),
        .alu_ctrl(n_alu_ctrl), .state(n_state), .illegal(n_illegal), .instr_cnt(n_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for a state, straight from the per-state strobe list.
    function automatic obs_t expect_out(input int s, input logic rdy, input logic [5:0] fn);
        obs_t e;
        e = '0;
        e.state   = 4'(s);
        e.illegal = (s == 12);
        case (s)
            0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.i_or_d = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; end
            5:  begin e.i_or_d = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 1; e.alu_ctrl = (fn == 6'h23) ? 3'd1 : 3'd0; end
            7:  begin e.reg_write = 1; e.reg_dst = 2'b01; end
            8:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'd2; end
            9:  e.reg_write = 1;
            10: begin e.alu_src_a = 1; e.alu_ctrl = 3'd1; e.pc_write_cond = 1; e.pc_source = 2'b01; end
            11: begin e.pc_write = 1; e.pc_source = 2'b10; e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic path_t path_of(input logic [5:0] o, input logic [5:0] f);
        path_t p;
        p.push_back(0);
        p.push_back(1);
        case (o)
            6'h23: begin p.push_back(2); p.push_back(3); p.push_back(4); end
            6'h2B: begin p.push_back(2); p.push_back(5); end
            6'h0D: begin p.push_back(8); p.push_back(9); end
            6'h04: p.push_back(10);
            6'h03: p.push_back(11);
            6'h00: begin
                if (f == 6'h21 || f == 6'h23) begin p.push_back(6); p.push_back(7); end
                else p.push_back(12);
            end
            default: p.push_back(12);
        endcase
        return p;
    endfunction

    function automatic bit retires(input int s, input logic rdy);
        return (s == 4 || s == 7 || s == 9 || s == 10 || s == 11 || (s == 5 && rdy));
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp, input int cact, input int cexp);
        n_vec++;
        if (act !== exp || cact != cexp) begin
            n_bad++;
            $display("FAIL %s: got outs=%h cnt=%0d, want outs=%h cnt=%0d", name, act, cact, exp, cexp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // One clock: drive mem_ready, check at negedge, advance the retire model after the edge.
    task automatic step(input int s, input logic rdy, input bit aw, input bit an);
        mem_ready = rdy;
        @(negedge clk);
        if (aw) begin
            chk($sformatf("w_s%0d", s), ow, expect_out(s, rdy, funct), int'(w_cnt), m_cnt_w % 4);
            if (w_ir_write) irp_acc++;
        end
        if (an) begin
            chk($sformatf("n_s%0d", s), onn, expect_out(s, 1'b1, funct), int'(n_cnt), m_cnt_n % 65536);
            if (!aw && n_ir_write) irp_acc++;
        end
        cyc_acc++;
        @(posedge clk);
        #1;
        if (aw && retires(s, rdy)) m_cnt_w++;
        if (an && retires(s, 1'b1)) m_cnt_n++;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int wf, input int wm, input bit aw, input bit an);
        path_t p;
        op = o; funct = f; zero = z;
        cyc_acc = 0; irp_acc = 0;
        p = path_of(o, f);
        foreach (p[i]) begin
            int s;
            s = p[i];
            if (aw && (s == 0 || s == 3 || s == 5)) begin
                repeat ((s == 0) ? wf : wm) step(s, 1'b0, aw, an);
                step(s, 1'b1, aw, an);
            end else begin
                step(s, 1'($urandom_range(1, 0)), aw, an);
            end
        end
    endtask

    task automatic reset_duts(input bit rel_w, input bit rel_n);
        rst_w_n = 1'b0; rst_n_n = 1'b0; mem_ready = 1'b1;
        m_cnt_w = 0; m_cnt_n = 0;
        #1;
        chk("w_reset_async", ow, expect_out(0, 1'b0, 6'h00), int'(w_cnt), 0);
        chk("n_reset_async", onn, expect_out(0, 1'b0, 6'h00), int'(n_cnt), 0);
        @(posedge clk);
        #1;
        chk("w_reset_hold", ow, expect_out(0, 1'b0, 6'h00), int'(w_cnt), 0);
        chk("n_reset_hold", onn, expect_out(0, 1'b0, 6'h00), int'(n_cnt), 0);
        rst_w_n = rel_w; rst_n_n = rel_n;
    endtask

    task automatic pick(output logic [5:0] o, output logic [5:0] f);
        int k;
        k = $urandom_range(6, 0);
        f = 6'($urandom);
        case (k)
            0: begin o = 6'h00; f = 6'h21; end
            1: begin o = 6'h00; f = 6'h23; end
            2: o = 6'h0D;
            3: o = 6'h23;
            4: o = 6'h2B;
            5: o = 6'h04;
            default: o = 6'h03;
        endcase
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[8];
        int         wrap_exp[5];
        logic [5:0] ro, rf;

        tbl[0] = '{6'h00, 6'h21, 1'b0, 4};
        tbl[1] = '{6'h00, 6'h23, 1'b0, 4};
        tbl[2] = '{6'h0D, 6'h15, 1'b0, 4};
        tbl[3] = '{6'h23, 6'h3E, 1'b0, 5};
        tbl[4] = '{6'h2B, 6'h01, 1'b0, 4};
        tbl[5] = '{6'h04, 6'h00, 1'b1, 3};
        tbl[6] = '{6'h04, 6'h00, 1'b0, 3};
        tbl[7] = '{6'h03, 6'h2A, 1'b0, 3};
        wrap_exp = '{1, 2, 3, 0, 1};

        n_vec = 0; n_bad = 0; m_cnt_w = 0; m_cnt_n = 0;
        op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        rst_w_n = 1'b0; rst_n_n = 1'b0;
        @(posedge clk);
        #1;

        // Table: every supported instruction on both instances, no memory waits.
        reset_duts(1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero, 0, 0, 1'b1, 1'b1);
            chk_int($sformatf("latency_vec%0d", i), cyc_acc, tbl[i].lat);
            chk_int($sformatf("ir_pulses_vec%0d", i), irp_acc, 1);
        end

        // lw with 3 FETCH and 2 MEMRD wait cycles on the waiting instance.
        reset_duts(1'b1, 1'b0);
        run_instr(6'h23, 6'h00, 1'b0, 3, 2, 1'b1, 1'b0);
        chk_int("lw_wait_cycles", cyc_acc, 10);
        chk_int("lw_wait_ir_pulses", irp_acc, 1);
        chk_int("lw_wait_cnt", int'(w_cnt), 1);

        // Counter wrap on the 2-bit instance.
        reset_duts(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            run_instr(6'h00, 6'h21, 1'b0, 0, 0, 1'b1, 1'b1);
            chk_int($sformatf("wrap_cnt%0d", i), int'(w_cnt), wrap_exp[i]);
        end
        chk_int("n_cnt_after_wrap", int'(n_cnt), 5);

        // Reset dropped mid-MEMRD, between clock edges.
        op = 6'h23; funct = 6'h07;
        step(0, 1'b1, 1'b1, 1'b1);
        step(1, 1'b1, 1'b1, 1'b1);
        step(2, 1'b1, 1'b1, 1'b1);
        mem_ready = 1'b0;
        #2;
        chk_int("w_in_memrd", int'(w_state), 3);
        rst_w_n = 1'b0; rst_n_n = 1'b0;
        m_cnt_w = 0; m_cnt_n = 0;
        #1;
        chk("w_midreset", ow, expect_out(0, 1'b0, 6'h00), int'(w_cnt), 0);
        chk("n_midreset", onn, expect_out(0, 1'b0, 6'h00), int'(n_cnt), 0);
        @(posedge clk);
        #1;
        rst_w_n = 1'b1; rst_n_n = 1'b1;
        run_instr(6'h03, 6'h11, 1'b0, 0, 0, 1'b1, 1'b1);

        // Illegal opcode: TRAP held for 20 cycles, then cleared by reset.
        run_instr(6'h3F, 6'h21, 1'b0, 0, 0, 1'b1, 1'b1);
        repeat (19) step(12, 1'($urandom_range(1, 0)), 1'b1, 1'b1);
        reset_duts(1'b1, 1'b1);
        run_instr(6'h00, 6'h23, 1'b0, 0, 0, 1'b1, 1'b1);

        // Unsupported R-type funct also traps.
        run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b1, 1'b1);
        repeat (4) step(12, 1'b1, 1'b1, 1'b1);
        reset_duts(1'b1, 1'b1);

        // Random mix with random memory waits on the waiting instance.
        reset_duts(1'b1, 1'b0);
        for (int i = 0; i < 150; i++) begin
            pick(ro, rf);
            run_instr(ro, rf, 1'($urandom_range(1, 0)), $urandom_range(3, 0), $urandom_range(3, 0), 1'b1, 1'b0);
        end

        // Random mix on the no-wait instance with mem_ready toggling freely.
        reset_duts(1'b0, 1'b1);
        for (int i = 0; i < 150; i++) begin
            pick(ro, rf);
            run_instr(ro, rf, 1'($urandom_range(1, 0)), 0, 0, 1'b0, 1'b1);
        end
        chk_int("n_cnt_random", int'(n_cnt), 150);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter WAIT_MEM, default 1, meaning: 1 = memory states wait for mem_ready; 0 = memory treated as always ready.
REQ-002 Parameter ALUCTRL_W, default 3, meaning: alu_ctrl width, >=2; codes zero-extended.
REQ-003 Parameter CNT_W, default 16, meaning: retired-instruction counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 op  in  6  instruction opcode from IR.
REQ-007 funct  in  6  R-type function field from IR.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write, reg_write, alu_src_a  out  1 each  standard multicycle datapath strobes and selects.
REQ-011 reg_dst, mem_to_reg, alu_src_b, pc_source  out  2 each  datapath mux selects.
REQ-012 alu_ctrl  out  ALUCTRL_W  ALU operation: ADD=0, SUB=1, OR=2.
REQ-013 state  out  4  current FSM state code, for debug.
REQ-014 illegal  out  1  sticky unsupported-instruction flag.
REQ-015 instr_cnt  out  CNT_W  count of retired instructions.

Function
REQ-016 The FSM SHALL use state codes FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, ORIEX=8, ORIWB=9, BEQ=10, JAL=11, TRAP=12.
REQ-017 Supported instructions: R-type op 0x00 with funct 0x21 (addu) or 0x23 (subu); ori 0x0D; lw 0x23; sw 0x2B; beq 0x04; jal 0x03.
REQ-018 Outputs SHALL be Moore decodes of state; the only exception is mem_ready gating of strobes in memory states. Every output not listed for a state SHALL be 0.
REQ-019 FETCH: mem_read=1, alu_src_b=01, alu_ctrl=ADD; ir_write=pc_write=ready; advance to DECODE when ready, otherwise hold.
REQ-020 DECODE: alu_src_b=11, alu_ctrl=ADD. Next state: lw/sw->MEMADR, R-type->RTEX, ori->ORIEX, beq->BEQ, jal->JAL, any other op or R-type funct->TRAP.
REQ-021 MEMADR: alu_src_a=1, alu_src_b=10, alu_ctrl=ADD. Next state: lw->MEMRD, sw->MEMWR.
REQ-022 MEMRD: mem_read=1, i_or_d=1; advance to MEMWB when ready. MEMWB: reg_write=1, mem_to_reg=01, reg_dst=00; next FETCH.
REQ-023 MEMWR: i_or_d=1, mem_write=1 while waiting; advance to FETCH when ready.
REQ-024 RTEX: alu_src_a=1, alu_src_b=00, alu_ctrl=ADD for funct 0x21 and SUB for 0x23. RTWB: reg_write=1, reg_dst=01; next FETCH.
REQ-025 ORIEX: alu_src_a=1, alu_src_b=10, alu_ctrl=OR. ORIWB: reg_write=1, reg_dst=00; next FETCH.
REQ-026 BEQ: alu_src_a=1, alu_ctrl=SUB, pc_write_cond=1, pc_source=01; next FETCH. The datapath takes the branch iff zero=1.
REQ-027 JAL: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10; next FETCH.
REQ-028 TRAP: illegal is set and the FSM stays in TRAP with all strobes 0 until reset.
REQ-029 "ready" SHALL mean mem_ready when WAIT_MEM=1 and constant 1 when WAIT_MEM=0.
REQ-030 instr_cnt SHALL increment by 1 on the clock edge leaving MEMWB, MEMWR (when ready), RTWB, ORIWB, BEQ or JAL, and wrap from all-ones to 0.
REQ-031 Latencies with WAIT_MEM=0: lw 5 cycles; sw, R-type and ori 4 cycles; beq and jal 3 cycles.

Reset
REQ-032 When rst_n=0: state=FETCH, illegal=0, instr_cnt=0, applied asynchronously.
REQ-033 While rst_n=0, every output SHALL be 0 except mem_read=1, alu_src_b=01 and alu_ctrl=ADD.
REQ-034 A reset asserted mid-instruction SHALL abort the instruction with no count increment; the first active edge after release samples FETCH.

Verification
REQ-035 WAIT_MEM=0, op=0x00, funct=0x21 -> states 0,1,6,7,0; alu_ctrl 0 in RTEX; reg_write=1, reg_dst=01 in RTWB; instr_cnt 0->1.
REQ-036 WAIT_MEM=1, lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> ir_write pulses exactly once; total 10 cycles; mem_to_reg=01 in MEMWB.
REQ-037 beq with zero=1, then beq with zero=0 -> pc_write_cond=1, pc_source=01, alu_ctrl=1 in both; instr_cnt +2.
REQ-038 jal -> in JAL pc_write=1, reg_dst=10, mem_to_reg=10; op=0x3F -> TRAP with illegal=1 held for 20 cycles; rst_n pulse clears it.
REQ-039 CNT_W=2: retire 5 R-types -> instr_cnt 1,2,3,0,1. Drop rst_n in MEMRD -> state=0 immediately, instr_cnt=0.
